// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: LSB-first payload serializer that merges returned CRC beats onto one TX stream
module crc_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 8,
  parameter int CRC_WAIT   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic                  SER_DATA,
  output logic                  ACTIVE,
  input  logic                  CRC_BIT,
  input  logic                  CRC_VALID,
  output logic                  TX_BIT,
  output logic                  TX_EN,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  UNDERRUN,
  output logic                  CRC_ERR
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(CRC_WIDTH + 1);
  localparam int WW = $clog2(CRC_WAIT + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CRC, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d, beat_nx;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d, wait_nx;
  logic last_q, last_d, ser_q, ser_d, active_q, active_d, tx_bit_q, tx_bit_d, tx_en_q, tx_en_d;
  logic underrun_q, underrun_d, crc_err_q, crc_err_d;
  logic at_end, accept, crc_short, crc_timeout;
  assign at_end = bit_cnt_q == BW'(DATA_WIDTH - 1);
  assign IN_READY = state_q == IDLE || (state_q == SHIFT && at_end && !last_q);
  assign accept = IN_VALID && IN_READY;
  assign beat_nx = beat_cnt_q + CW'(CRC_VALID);
  assign wait_nx = wait_cnt_q + WW'(beat_cnt_q == '0 && !CRC_VALID);
  // a gap after the first beat means the CRC stage delivered a short CRC
  assign crc_short = beat_cnt_q != '0 && !CRC_VALID;
  assign crc_timeout = wait_nx == WW'(CRC_WAIT);
  assign SER_DATA = ser_q;
  assign ACTIVE = active_q;
  assign TX_BIT = tx_bit_q;
  assign TX_EN = tx_en_q;
  assign BUSY = state_q != IDLE;
  assign FRAME_DONE = state_q == DONE;
  assign UNDERRUN = underrun_q;
  assign CRC_ERR = crc_err_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_cnt_d = bit_cnt_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    last_d = last_q;
    ser_d = ser_q;
    active_d = active_q;
    tx_bit_d = tx_bit_q;
    tx_en_d = tx_en_q;
    underrun_d = underrun_q;
    crc_err_d = crc_err_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = IN_DATA;
      ser_d = IN_DATA[0];
      tx_bit_d = IN_DATA[0];
      active_d = 1'b1;
      tx_en_d = 1'b1;
      bit_cnt_d = '0;
      last_d = IN_LAST;
      underrun_d = underrun_q && state_q != IDLE;
      crc_err_d = crc_err_q && state_q != IDLE;
    end else begin
      case (state_q)
        SHIFT: begin
          if (!at_end) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ser_d = shreg_q[bit_cnt_d];
            tx_bit_d = shreg_q[bit_cnt_d];
          end else begin
            state_d = CRC;
            active_d = 1'b0;
            tx_en_d = 1'b0;
            ser_d = 1'b0;
            tx_bit_d = 1'b0;
            wait_cnt_d = '0;
            beat_cnt_d = '0;
            underrun_d = underrun_q || !last_q;
          end
        end
        CRC: begin
          tx_bit_d = CRC_BIT;
          tx_en_d = CRC_VALID;
          beat_cnt_d = beat_nx;
          wait_cnt_d = wait_nx;
          crc_err_d = crc_err_q || crc_short || crc_timeout;
          state_d = (crc_short || crc_timeout || beat_nx == CW'(CRC_WIDTH)) ? DONE : CRC;
        end
        DONE: begin
          tx_en_d = 1'b0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      last_q <= 1'b0;
      ser_q <= 1'b0;
      active_q <= 1'b0;
      tx_bit_q <= 1'b0;
      tx_en_q <= 1'b0;
      underrun_q <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      last_q <= last_d;
      ser_q <= ser_d;
      active_q <= active_d;
      tx_bit_q <= tx_bit_d;
      tx_en_q <= tx_en_d;
      underrun_q <= underrun_d;
      crc_err_q <= crc_err_d;
    end
  end
endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb_crc_frame_serializer: directed checks of framing, CRC merge, underrun, CRC errors and reset abort
module tb_crc_frame_serializer;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] IN_DATA = '0;
  logic IN_VALID = 1'b0, IN_LAST = 1'b0, CRC_BIT = 1'b0, CRC_VALID = 1'b0;
  logic IN_READY, SER_DATA, ACTIVE, TX_BIT, TX_EN, BUSY, FRAME_DONE, UNDERRUN, CRC_ERR;
  int checks = 0, errors = 0, act_cnt = 0, n;
  always #5 CLK = ~CLK;
  crc_frame_serializer #(.DATA_WIDTH(8), .CRC_WIDTH(8), .CRC_WAIT(4)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .SER_DATA(SER_DATA), .ACTIVE(ACTIVE), .CRC_BIT(CRC_BIT),
    .CRC_VALID(CRC_VALID), .TX_BIT(TX_BIT), .TX_EN(TX_EN), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .UNDERRUN(UNDERRUN), .CRC_ERR(CRC_ERR)
  );
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic start(input logic [7:0] w, input logic last);
    IN_DATA = w;
    IN_LAST = last;
    IN_VALID = 1'b1;
    check("rdy_idle", IN_READY, 1);
    tick;
  endtask
  task automatic shift_word(input logic [7:0] w, input logic rdy7, input int nb);
    for (int i = 0; i < nb; i++) begin
      check("ser", SER_DATA, w[i]);
      check("txb", TX_BIT, w[i]);
      check("act", ACTIVE, 1);
      check("txen", TX_EN, 1);
      check("rdy", IN_READY, (i == 7) && rdy7);
      act_cnt += int'(ACTIVE);
      tick;
    end
  endtask
  task automatic send_crc(input logic [7:0] p, input int nb);
    check("act_fall", ACTIVE, 0);
    check("gap1", TX_EN, 0);
    check("busy_crc", BUSY, 1);
    tick;
    check("gap2", TX_EN, 0);
    for (int k = 0; k < nb; k++) begin
      CRC_VALID = 1'b1;
      CRC_BIT = p[k];
      check("rdy_crc", IN_READY, 0);
      check("done_early", FRAME_DONE, 0);
      tick;
      check("crc_en", TX_EN, 1);
      check("crc_bit", TX_BIT, p[k]);
    end
    CRC_VALID = 1'b0;
    CRC_BIT = 1'b0;
    if (nb < 8) tick;
    check("done", FRAME_DONE, 1);
    check("crc_err", CRC_ERR, nb < 8);
    tick;
    check("done_pulse", FRAME_DONE, 0);
    check("idle", BUSY, 0);
    check("txen_idle", TX_EN, 0);
  endtask
  initial begin
    tick;
    tick;
    check("rst_act", ACTIVE, 0);
    check("rst_txen", TX_EN, 0);
    check("rst_ser", SER_DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", FRAME_DONE, 0);
    check("rst_und", UNDERRUN, 0);
    check("rst_err", CRC_ERR, 0);
    check("rst_rdy", IN_READY, 1);
    RST = 1'b0;
    tick;
    start(8'hA5, 1'b1);
    IN_VALID = 1'b0;
    shift_word(8'hA5, 1'b0, 8);
    send_crc(8'hD3, 8);
    act_cnt = 0;
    start(8'h01, 1'b0);
    IN_DATA = 8'h80;
    shift_word(8'h01, 1'b1, 8);
    IN_DATA = 8'hFF;
    IN_LAST = 1'b1;
    shift_word(8'h80, 1'b1, 8);
    shift_word(8'hFF, 1'b0, 8);
    check("act_len", act_cnt, 24);
    send_crc(8'h6E, 8);
    check("rdy_after", IN_READY, 1);
    IN_VALID = 1'b0;
    IN_LAST = 1'b0;
    start(8'h3C, 1'b0);
    IN_VALID = 1'b0;
    shift_word(8'h3C, 1'b1, 8);
    check("underrun", UNDERRUN, 1);
    send_crc(8'h95, 8);
    check("und_sticky", UNDERRUN, 1);
    start(8'h5A, 1'b1);
    IN_VALID = 1'b0;
    check("und_clear", UNDERRUN, 0);
    shift_word(8'h5A, 1'b0, 8);
    n = 0;
    while (!FRAME_DONE && n < 10) begin
      tick;
      n++;
    end
    check("to_cycles", n, 4);
    check("to_err", CRC_ERR, 1);
    check("to_txen", TX_EN, 0);
    tick;
    check("to_idle", BUSY, 0);
    start(8'hC3, 1'b1);
    IN_VALID = 1'b0;
    check("err_clear", CRC_ERR, 0);
    shift_word(8'hC3, 1'b0, 8);
    send_crc(8'hB7, 5);
    start(8'h11, 1'b0);
    IN_DATA = 8'h22;
    shift_word(8'h11, 1'b1, 8);
    shift_word(8'h22, 1'b1, 3);
    RST = 1'b1;
    tick;
    check("abort_act", ACTIVE, 0);
    check("abort_busy", BUSY, 0);
    check("abort_txen", TX_EN, 0);
    check("abort_done", FRAME_DONE, 0);
    RST = 1'b0;
    IN_VALID = 1'b0;
    check("abort_rdy", IN_READY, 1);
    tick;
    check("abort_done2", FRAME_DONE, 0);
    check("abort_idle", BUSY, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Upstream stage of the serial CRC generator. Accepts bytes over a valid/ready handshake and shifts them out LSB-first on SER_DATA with ACTIVE framing, which drives the CRC stage's DATA/ACTIVE inputs.
- When ACTIVE drops, it collects the serial CRC bits (CRC_BIT/CRC_VALID) returned by the CRC stage.
- TX_BIT/TX_EN carry a single merged stream: payload bits followed by CRC bits.
- Reports frame completion and framing errors.

Parameters:
- DATA_WIDTH, 8: bits per input word; also the shift length per word.
- CRC_WIDTH, 8: CRC bits expected from the CRC stage per frame.
- CRC_WAIT, 4: max cycles in CRC phase to wait for the first CRC_VALID before flagging error.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. Synchronous, active-high.
- IN_DATA  in  DATA_WIDTH  payload word.
- IN_VALID  in  1  IN_DATA valid.
- IN_LAST  in  1  word is final word of frame; qualified by IN_VALID.
- IN_READY  out  1  word accepted on edge where IN_VALID && IN_READY.
- SER_DATA  out  1  serial payload bit, to the CRC stage DATA input.
- ACTIVE  out  1  payload framing, to the CRC stage ACTIVE input.
- CRC_BIT  in  1  serial CRC bit from the CRC stage.
- CRC_VALID  in  1  CRC_BIT valid.
- TX_BIT  out  1  merged line bit (payload then CRC).
- TX_EN  out  1  TX_BIT valid.
- BUSY  out  1  state != IDLE.
- FRAME_DONE  out  1  one-cycle pulse at frame end.
- UNDERRUN  out  1  sticky until next frame accept: word missing at word boundary.
- CRC_ERR  out  1  sticky until next frame accept: CRC beats missing or short.

Behaviour:
- Reset: synchronous, active-high. Next edge forces:
  - state IDLE;
  - all outputs 0 (IN_READY reads 1 combinationally once in IDLE);
  - bit/beat/wait counters 0.
- Reset mid-frame aborts silently (no FRAME_DONE). The system resets the CRC stage alongside.
- Registers:
  - shreg[DATA_WIDTH-1:0]
  - bit_cnt: clog2(DATA_WIDTH) bits
  - last_flag
  - beat_cnt: clog2(CRC_WIDTH+1) bits
  - wait_cnt
- States: IDLE, SHIFT, CRC, DONE.
- IN_READY, combinational from state only:
  - 1 in IDLE;
  - 1 in SHIFT when bit_cnt==DATA_WIDTH-1 && !last_flag;
  - else 0. Never depends on IN_VALID.
- IDLE:
  - On accept: shreg<=IN_DATA, SER_DATA<=IN_DATA[0], ACTIVE<=1, TX_BIT<=IN_DATA[0], TX_EN<=1, bit_cnt<=0, last_flag<=IN_LAST.
  - Also clear UNDERRUN and CRC_ERR; go to SHIFT.
- SHIFT:
  - Each edge with bit_cnt<DATA_WIDTH-1: bit_cnt++; SER_DATA and TX_BIT <= shreg[bit_cnt+1].
  - Edge at bit_cnt==DATA_WIDTH-1, cases in priority order:
    - last_flag: ACTIVE<=0, TX_EN<=0, SER_DATA<=0, wait_cnt<=0, beat_cnt<=0; go CRC.
    - IN_VALID: accept next word with the same load as IDLE, minus flag clears. ACTIVE stays high, so there is zero-gap continuation.
    - else: UNDERRUN<=1; end frame exactly as the last_flag case (CRC covers bits sent so far).
  - ACTIVE is high for exactly N*DATA_WIDTH contiguous cycles for an N-word frame with no underrun.
- CRC:
  - IN_READY=0; IN_VALID is ignored.
  - Each edge: TX_BIT<=CRC_BIT, TX_EN<=CRC_VALID.
  - If CRC_VALID: beat_cnt++.
  - If beat_cnt==0 && !CRC_VALID: wait_cnt++.
  - Exit to DONE when any of:
    - beat_cnt reaches CRC_WIDTH;
    - wait_cnt reaches CRC_WAIT (CRC_ERR<=1);
    - CRC_VALID low after beat_cnt>0 but <CRC_WIDTH (CRC_ERR<=1).
  - Beats beyond CRC_WIDTH are not forwarded.
- DONE: FRAME_DONE=1 for one cycle, TX_EN=0; go IDLE.
- Gap: paired with the CRC stage (registered CRC output one edge after ACTIVE falls), TX_EN is low for exactly 2 cycles between the last payload bit and the first CRC bit.

Test Plan:
- Single word 0xA5, IN_LAST=1:
  - SER_DATA/TX_BIT = 1,0,1,0,0,1,0,1 over 8 cycles with ACTIVE=TX_EN=1;
  - then TX_EN=0 for 2 cycles, 8 TX_EN beats equal to the CRC stage's bits;
  - then FRAME_DONE pulse, BUSY=0.
- Back-to-back 0x01,0x80,0xFF (IN_VALID held, IN_LAST on third):
  - ACTIVE high exactly 24 contiguous cycles;
  - IN_READY high only on cycles 0, 8, 16;
  - bit stream 10000000 00000001 11111111.
- Underrun: word 0x3C with IN_LAST=0, IN_VALID low afterwards:
  - ACTIVE falls after 8 cycles, UNDERRUN=1;
  - CRC phase completes, FRAME_DONE pulses;
  - next accept clears UNDERRUN.
- CRC timeout, CRC_WAIT=4, CRC_VALID held 0: CRC_ERR=1 and FRAME_DONE 4 cycles after entering CRC. Short CRC: 5 beats then CRC_VALID=0 -> CRC_ERR=1.
- RST=1 at bit 3 of the second word: next edge ACTIVE=0, BUSY=0, TX_EN=0, no FRAME_DONE; IN_READY=1 once RST releases.
- IN_VALID=1 throughout CRC phase: IN_READY stays 0, no word consumed until after FRAME_DONE.
